lfsr8_seq_ctrl: RTL and testbench

Sequencing controller for the team's 8-bit Fibonacci LFSR datapath.
- Owns the LFSR state register and drives the per-bit seed/feedback select: the seed is loaded when select is in seed mode, otherwise the feedback shift is applied.
- Runs a programmed number of steps, pacing them with a step enable, then reports completion.
- Sits between a host/test sequencer and downstream PRBS consumers.

---
 rtl/lfsr8_seq_ctrl.sv | 110 +++++++++++
 tb/tb_lfsr8_seq_ctrl.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr8_seq_ctrl.sv
// Sequencing controller for an 8-bit Fibonacci LFSR: loads a seed, runs a
// programmed number of paced steps, and reports completion/period events.
module lfsr8_seq_ctrl #(
  parameter logic [7:0] TAPS  = 8'hB8,
  parameter int         CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [7:0]       seed,
  input  logic [CNT_W-1:0] num_steps,
  input  logic             step_en,
  input  logic             abort,
  output logic [7:0]       q,
  output logic             out_valid,
  output logic             busy,
  output logic             done,
  output logic             period_hit,
  output logic             seed_err
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [7:0]       seed_r;
  logic [7:0]       q_step;
  logic [CNT_W-1:0] cnt;
  logic             accept;
  logic             load_en;
  logic             step_do;

  function automatic logic [7:0] lfsr_next(input logic [7:0] v);
    return {v[6:0], ^(v & TAPS)};
  endfunction

  assign q_step = lfsr_next(q);

  // Abort wins over step_en in RUN; in LOAD the seed load still happens on abort.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    load_en   = 1'b0;
    step_do   = 1'b0;
    case (state)
      IDLE: begin
        if (start && (seed != 8'h00)) begin
          accept    = 1'b1;
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        load_en = 1'b1;
        if (abort)
          state_nxt = IDLE;
        else if (cnt == '0)
          state_nxt = DONE;
        else
          state_nxt = RUN;
      end
      RUN: begin
        if (abort) begin
          state_nxt = IDLE;
        end else if (step_en) begin
          step_do = 1'b1;
          if (cnt == CNT_W'(1))
            state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // Datapath and single-cycle status pulses, all registered off the decisions above.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q          <= '0;
      seed_r     <= '0;
      cnt        <= '0;
      out_valid  <= 1'b0;
      period_hit <= 1'b0;
      seed_err   <= 1'b0;
    end else begin
      out_valid  <= step_do;
      period_hit <= step_do && (q_step == seed_r);
      seed_err   <= (state == IDLE) && start && (seed == 8'h00);
      if (accept) begin
        seed_r <= seed;
        cnt    <= num_steps;
      end
      if (load_en) begin
        q <= seed_r;
      end else if (step_do) begin
        q   <= q_step;
        cnt <= cnt - CNT_W'(1);
      end
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_lfsr8_seq_ctrl.sv
// Randomized self-checking bench for lfsr8_seq_ctrl against a step-list model
// of the LFSR sequence and run protocol.
module tb_lfsr8_seq_ctrl;

  localparam int CNT_W = 16;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [7:0]       seed;
  logic [CNT_W-1:0] num_steps;
  logic             step_en;
  logic             abort;
  logic [7:0]       q;
  logic             out_valid;
  logic             busy;
  logic             done;
  logic             period_hit;
  logic             seed_err;

  int compared   = 0;
  int mismatched = 0;

  lfsr8_seq_ctrl #(.TAPS(8'hB8), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .seed(seed),
    .num_steps(num_steps), .step_en(step_en), .abort(abort),
    .q(q), .out_valid(out_valid), .busy(busy), .done(done),
    .period_hit(period_hit), .seed_err(seed_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Polynomial x^8+x^6+x^5+x^4+1: shift left, new LSB = parity of bits 7,5,4,3.
  function automatic logic [7:0] ref_step(input logic [7:0] v);
    int ones;
    int nv;
    ones = $countones(v & 8'hB8);
    nv   = (int'(v) * 2) % 256 + (ones % 2);
    return 8'(nv);
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start_load(input logic [7:0] s, input int n);
    start = 1'b1; seed = s; num_steps = CNT_W'(n); step_en = 1'b0; abort = 1'b0;
    tick();
    start = 1'b0;
    tick();
  endtask

  // en_pct < 0 selects a strict 1,0,1,0 enable pattern.
  task automatic do_run(input logic [7:0] s, input int n, input int en_pct, input bit noisy,
                        output int run_cyc, output int hits);
    logic [7:0] mq;
    int         steps;
    logic       en;
    logic       e_ov, e_ph, e_done;
    mq = s; steps = 0; run_cyc = 0; hits = 0;
    start = 1'b1; seed = s; num_steps = CNT_W'(n); step_en = 1'b0; abort = 1'b0;
    tick();
    compared++;
    if (busy !== 1'b1 || done !== 1'b0 || out_valid !== 1'b0 || seed_err !== 1'b0) begin
      mismatched++;
      $display("FAIL load_entry busy=%b done=%b ov=%b serr=%b required 1/0/0/0", busy, done, out_valid, seed_err);
    end
    start = noisy ? 1'($urandom_range(1)) : 1'b0;
    seed = 8'($urandom); num_steps = CNT_W'($urandom);
    tick();
    compared++;
    if (q !== s || busy !== 1'b1 || out_valid !== 1'b0 || done !== (n == 0)) begin
      mismatched++;
      $display("FAIL after_load q=%h busy=%b ov=%b done=%b required q=%h 1/0/%0d", q, busy, out_valid, done, s, n == 0);
    end
    while (steps < n) begin
      if (run_cyc > 3000) begin
        compared++; mismatched++;
        $display("FAIL run_timeout steps=%0d required %0d", steps, n);
        break;
      end
      en = (en_pct < 0) ? (run_cyc % 2 == 0) : ($urandom_range(99) < en_pct);
      step_en = en;
      start = noisy ? 1'($urandom_range(1)) : 1'b0;
      seed = 8'($urandom); num_steps = CNT_W'($urandom);
      tick();
      run_cyc++;
      e_ov = en; e_ph = 1'b0; e_done = 1'b0;
      if (en) begin
        mq = ref_step(mq);
        steps++;
        e_ph = (mq == s);
        e_done = (steps == n);
      end
      if (period_hit === 1'b1) hits++;
      compared++;
      if (q !== mq || out_valid !== e_ov || period_hit !== e_ph || done !== e_done ||
          busy !== 1'b1 || seed_err !== 1'b0) begin
        mismatched++;
        $display("FAIL run_step%0d q=%h ov=%b ph=%b done=%b busy=%b serr=%b required q=%h %b/%b/%b/1/0",
                 steps, q, out_valid, period_hit, done, busy, seed_err, mq, e_ov, e_ph, e_done);
      end
    end
    step_en = 1'b0;
    start = noisy ? 1'b1 : 1'b0;
    seed = 8'($urandom_range(255, 1));
    tick();
    start = 1'b0;
    compared++;
    if (busy !== 1'b0 || done !== 1'b0 || out_valid !== 1'b0 || q !== mq) begin
      mismatched++;
      $display("FAIL after_done busy=%b done=%b ov=%b q=%h required 0/0/0 q=%h", busy, done, out_valid, q, mq);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; seed = '0; num_steps = '0; step_en = 1'b0; abort = 1'b0;
    tick(); tick();
    compared++;
    if (q !== 8'h00 || out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
        period_hit !== 1'b0 || seed_err !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_state q=%h ov=%b busy=%b done=%b ph=%b serr=%b required all 0",
               q, out_valid, busy, done, period_hit, seed_err);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset_mid_run;
    start_load(8'h01, 10);
    step_en = 1'b1;
    tick(); tick(); tick();
    #2 rst_n = 1'b0;
    #1;
    compared++;
    if (q !== 8'h00 || out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
        period_hit !== 1'b0 || seed_err !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_async q=%h ov=%b busy=%b done=%b ph=%b serr=%b required all 0",
               q, out_valid, busy, done, period_hit, seed_err);
    end
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      compared++;
      if (done !== 1'b0 || busy !== 1'b0 || q !== 8'h00 || out_valid !== 1'b0) begin
        mismatched++;
        $display("FAIL reset_after%0d done=%b busy=%b q=%h ov=%b required 0/0/00/0", i, done, busy, q, out_valid);
      end
    end
    step_en = 1'b0;
  endtask

  task automatic test_five_steps;
    int rc, h;
    do_run(8'h01, 5, 100, 1'b0, rc, h);
    compared++;
    if (q !== 8'h23 || rc !== 5) begin
      mismatched++;
      $display("FAIL five_steps q=%h cycles=%0d required 23 5", q, rc);
    end
  endtask

  task automatic test_period;
    int rc, h;
    do_run(8'h01, 255, 100, 1'b0, rc, h);
    compared++;
    if (h !== 1 || q !== 8'h01 || rc !== 255) begin
      mismatched++;
      $display("FAIL period hits=%0d q=%h cycles=%0d required 1 01 255", h, q, rc);
    end
  endtask

  task automatic test_toggle;
    int rc, h;
    do_run(8'h01, 4, -1, 1'b0, rc, h);
    compared++;
    if (rc !== 7 || q !== 8'h11) begin
      mismatched++;
      $display("FAIL toggle cycles=%0d q=%h required 7 11", rc, q);
    end
  endtask

  task automatic test_zero_steps;
    int rc, h;
    do_run(8'h5A, 0, 100, 1'b0, rc, h);
    compared++;
    if (rc !== 0 || q !== 8'h5A) begin
      mismatched++;
      $display("FAIL zero_steps cycles=%0d q=%h required 0 5a", rc, q);
    end
  endtask

  task automatic test_seed_err;
    logic [7:0] q0;
    q0 = q;
    start = 1'b1; seed = 8'h00; num_steps = CNT_W'(3);
    tick();
    start = 1'b0;
    compared++;
    if (seed_err !== 1'b1 || busy !== 1'b0 || q !== q0) begin
      mismatched++;
      $display("FAIL seed_err_pulse serr=%b busy=%b q=%h required 1/0 q=%h", seed_err, busy, q, q0);
    end
    tick();
    compared++;
    if (seed_err !== 1'b0 || busy !== 1'b0 || q !== q0) begin
      mismatched++;
      $display("FAIL seed_err_clear serr=%b busy=%b q=%h required 0/0 q=%h", seed_err, busy, q, q0);
    end
  endtask

  task automatic test_abort;
    start_load(8'h01, 10);
    step_en = 1'b1;
    tick(); tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    compared++;
    if (q !== 8'h04 || busy !== 1'b0 || out_valid !== 1'b0 || done !== 1'b0) begin
      mismatched++;
      $display("FAIL abort_run q=%h busy=%b ov=%b done=%b required 04/0/0/0", q, busy, out_valid, done);
    end
    tick();
    step_en = 1'b0;
    compared++;
    if (q !== 8'h04 || done !== 1'b0 || out_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL abort_hold q=%h done=%b ov=%b required 04/0/0", q, done, out_valid);
    end
    // abort is ignored in IDLE but honoured in LOAD, where the seed still loads
    start = 1'b1; seed = 8'hC3; num_steps = CNT_W'(6); abort = 1'b1;
    tick();
    start = 1'b0;
    compared++;
    if (busy !== 1'b1) begin
      mismatched++;
      $display("FAIL abort_idle busy=%b required 1", busy);
    end
    tick();
    abort = 1'b0;
    compared++;
    if (q !== 8'hC3 || busy !== 1'b0 || done !== 1'b0) begin
      mismatched++;
      $display("FAIL abort_load q=%h busy=%b done=%b required c3/0/0", q, busy, done);
    end
  endtask

  task automatic test_back_to_back;
    int rc, h;
    do_run(8'h01, 3, 100, 1'b1, rc, h);
    do_run(8'hA7, 6, 70, 1'b1, rc, h);
  endtask

  task automatic test_random;
    int rc, h;
    for (int i = 0; i < 8; i++)
      do_run(8'($urandom_range(255, 1)), int'($urandom_range(40)), 60, 1'b1, rc, h);
  endtask

  initial begin
    test_reset();
    test_five_steps();
    test_period();
    test_toggle();
    test_zero_steps();
    test_seed_err();
    test_abort();
    test_reset_mid_run();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
